// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: moves one WORD_W-bit processor word to or from a narrow
// asynchronous SRAM as BEATS consecutive LANE_W-bit locations, most-significant
// lane first. Each beat holds the address for WAIT+1 clocks; writes add one
// hold clock with WE_n released so address and data stay valid past the strobe.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; request, address and data latched here
// ACCESS | strobes active for the current beat, wcnt counts 0..WAIT
// HOLD   | write only: WE_n released, address/data/CE_n kept for one clock
// DONE   | mem_ack high until the request is dropped
module sram_word_ctrl #(
  parameter int WORD_W  = 36,
  parameter int LANE_W  = 9,
  parameter int BEATS   = 4,
  parameter int ADDR_W  = 18,
  parameter int SRAM_DW = 16,
  parameter int WAIT    = 1,
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [WORD_W-1:0]           mem_write_data,
  input  logic                        mem_read,
  input  logic                        mem_write,
  output logic [WORD_W-1:0]           mem_read_data,
  output logic                        mem_ack,
  output logic [ADDR_W+BEAT_BITS-1:0] sram_addr,
  output logic [SRAM_DW-1:0]          sram_data_out,
  input  logic [SRAM_DW-1:0]          sram_data_in,
  output logic                        sram_data_oe,
  output logic                        CE_n,
  output logic                        OE_n,
  output logic                        WE_n,
  output logic                        UB_n,
  output logic                        LB_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0]           WAIT_C    = 4'(WAIT);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  // Lanes of 8 bits or less never touch the upper byte of the SRAM.
  localparam bit                   USE_UB    = (LANE_W > 8);

  logic [1:0]           state, state_nx;
  logic [BEAT_BITS-1:0] beat, beat_nx;
  logic [3:0]           wcnt, wcnt_nx;
  logic                 op_wr, op_wr_nx;
  logic [ADDR_W-1:0]    addr_q, addr_nx;
  logic [WORD_W-1:0]    wdata_q, wdata_nx;
  logic                 capture;
  logic [LANE_W-1:0]    lane_nx;
  logic                 act_nx;
  logic                 rd_strobe_nx;
  logic                 wr_strobe_nx;
  logic                 req;
  logic                 unused_in;

  assign req = mem_read | mem_write;

  // Only the low LANE_W bits of the SRAM bus carry data.
  assign unused_in = &{1'b0, sram_data_in};

  // Next-state, beat/wait sequencing and request latching.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    wcnt_nx  = wcnt;
    op_wr_nx = op_wr;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          op_wr_nx = mem_write;
          addr_nx  = mem_addr;
          wdata_nx = mem_write_data;
          beat_nx  = '0;
          wcnt_nx  = '0;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wcnt == WAIT_C) begin
          wcnt_nx = '0;
          if (op_wr) begin
            state_nx = S_HOLD;
          end else begin
            capture = 1'b1;
            if (beat == LAST_BEAT) begin
              beat_nx  = '0;
              state_nx = S_DONE;
            end else begin
              beat_nx = beat + BEAT_BITS'(1);
            end
          end
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end
      S_HOLD: begin
        if (beat == LAST_BEAT) begin
          beat_nx  = '0;
          state_nx = S_DONE;
        end else begin
          beat_nx  = beat + BEAT_BITS'(1);
          state_nx = S_ACCESS;
        end
      end
      S_DONE: begin
        if (!req) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        beat_nx  = '0;
        wcnt_nx  = '0;
      end
    endcase
  end

  // Pick the write lane for the beat that will be on the bus next clock.
  always_comb begin
    lane_nx = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_nx == BEAT_BITS'(k)) begin
        lane_nx = wdata_nx[WORD_W-1-k*LANE_W -: LANE_W];
      end
    end
  end

  // Strobe intent for next clock; read and write strobes are mutually
  // exclusive because they key off the latched op.
  always_comb begin
    act_nx       = (state_nx == S_ACCESS) || (state_nx == S_HOLD);
    rd_strobe_nx = (state_nx == S_ACCESS) && !op_wr_nx;
    wr_strobe_nx = (state_nx == S_ACCESS) && op_wr_nx;
  end

  // Controller state and latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      beat    <= '0;
      wcnt    <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      beat    <= beat_nx;
      wcnt    <= wcnt_nx;
      op_wr   <= op_wr_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Registered SRAM strobes, bus enable and processor acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      CE_n         <= 1'b1;
      OE_n         <= 1'b1;
      WE_n         <= 1'b1;
      UB_n         <= 1'b1;
      LB_n         <= 1'b1;
      sram_data_oe <= 1'b0;
      mem_ack      <= 1'b0;
    end else begin
      CE_n         <= !act_nx;
      OE_n         <= !rd_strobe_nx;
      WE_n         <= !wr_strobe_nx;
      LB_n         <= !act_nx;
      UB_n         <= USE_UB ? !act_nx : 1'b1;
      sram_data_oe <= act_nx && op_wr_nx;
      mem_ack      <= (state_nx == S_DONE);
    end
  end

  // Registered SRAM address and zero-extended write lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_addr     <= '0;
      sram_data_out <= '0;
    end else begin
      sram_addr     <= {addr_nx, beat_nx};
      sram_data_out <= (act_nx && op_wr_nx) ? SRAM_DW'(lane_nx) : '0;
    end
  end

  // Read lanes land in mem_read_data one beat at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_data <= '0;
    end else if (capture) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat == BEAT_BITS'(k)) begin
          mem_read_data[WORD_W-1-k*LANE_W -: LANE_W] <= sram_data_in[LANE_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: default 36/9/4 WAIT=1 instance plus a 32/8/4
// WAIT=0 instance, each attached to a simple behavioural SRAM array.
module tb_sram_word_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // default instance
  logic [17:0] mem_addr;
  logic [35:0] mem_write_data;
  logic        mem_read, mem_write;
  logic [35:0] mem_read_data;
  logic        mem_ack;
  logic [19:0] sram_addr;
  logic [15:0] sram_data_out, sram_data_in;
  logic        sram_data_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  sram_word_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out),
    .sram_data_in(sram_data_in), .sram_data_oe(sram_data_oe),
    .CE_n(ce_n), .OE_n(oe_n), .WE_n(we_n), .UB_n(ub_n), .LB_n(lb_n)
  );

  // 32/8 variant, zero wait states
  logic [7:0]  a2;
  logic [31:0] wd2, rdata2;
  logic        rd2, wr2, ack2;
  logic [9:0]  saddr2;
  logic [15:0] sdout2, sdin2;
  logic        soe2, ce2, oe2, we2, ub2, lb2;

  sram_word_ctrl #(.WORD_W(32), .LANE_W(8), .BEATS(4), .ADDR_W(8), .SRAM_DW(16), .WAIT(0)) dut2 (
    .clk(clk), .reset(reset),
    .mem_addr(a2), .mem_write_data(wd2),
    .mem_read(rd2), .mem_write(wr2),
    .mem_read_data(rdata2), .mem_ack(ack2),
    .sram_addr(saddr2), .sram_data_out(sdout2),
    .sram_data_in(sdin2), .sram_data_oe(soe2),
    .CE_n(ce2), .OE_n(oe2), .WE_n(we2), .UB_n(ub2), .LB_n(lb2)
  );

  // Behavioural SRAMs; the preload port lets the bench seed contents.
  logic [15:0] sram_mem [0:(1<<20)-1];
  logic        pl_en;
  logic [19:0] pl_addr;
  logic [15:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_data_oe ? sram_data_out : 16'hxxxx;
  end
  assign sram_data_in = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 16'hxxxx;

  logic [15:0] mem2 [0:1023];
  logic        pl2_en;
  logic [9:0]  pl2_addr;
  logic [15:0] pl2_data;
  always @(posedge clk) begin
    if (pl2_en) mem2[pl2_addr] <= pl2_data;
    else if (!ce2 && !we2) mem2[saddr2] <= soe2 ? sdout2 : 16'hxxxx;
  end
  assign sdin2 = (!ce2 && !oe2) ? mem2[saddr2] : 16'hxxxx;

  // Reference: whole-word memory keyed by processor address.
  logic [35:0] ref_mem [logic [17:0]];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] lane_of(input logic [35:0] w, input int k);
    return 9'((w >> (9 * (3 - k))) & 36'h1FF);
  endfunction

  task automatic preload(input logic [17:0] a, input logic [35:0] w);
    for (int k = 0; k < 4; k++) begin
      pl_en   = 1'b1;
      pl_addr = {a, 2'(k)};
      pl_data = {7'($urandom), lane_of(w, k)};
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    ref_mem[a] = w;
  endtask

  task automatic preload2(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      pl2_en   = 1'b1;
      pl2_addr = {a, 2'(k)};
      pl2_data = {8'($urandom), 8'((w >> (8 * (3 - k))) & 32'hFF)};
      @(posedge clk); #1;
    end
    pl2_en = 1'b0;
  endtask

  // One transaction on the default instance; lat = edges from sampling to ack.
  task automatic run_txn(input bit rd, input bit wr, input logic [17:0] a, input logic [35:0] d,
                         input bit pulse, input int hold,
                         output int lat, output bit saw_we, output bit saw_oe, output bit clash);
    saw_we = 1'b0; saw_oe = 1'b0; clash = 1'b0; lat = 0;
    mem_read = rd; mem_write = wr; mem_addr = a; mem_write_data = d;
    @(posedge clk); #1;
    mem_addr = 18'($urandom);
    mem_write_data = {4'($urandom), 32'($urandom)};
    if (pulse) begin mem_read = 1'b0; mem_write = 1'b0; end
    while (!mem_ack && lat < 200) begin
      if (!we_n) saw_we = 1'b1;
      if (!oe_n) saw_oe = 1'b1;
      if (sram_data_oe && !oe_n) clash = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!mem_ack) begin
      chk("ack_timeout", mem_ack, 1);
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    if (!pulse) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("ack_held", mem_ack, 1);
        chk("no_rerun_ce", ce_n, 1);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", mem_ack, 0);
  endtask

  task automatic run2(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output bit ub_seen);
    rd2 = rd; wr2 = wr; a2 = a; wd2 = d;
    @(posedge clk); #1;
    lat = 0; ub_seen = 1'b0;
    while (!ack2 && lat < 100) begin
      if (!ub2) ub_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("v_ack_seen", ack2, 1);
    rd2 = 1'b0; wr2 = 1'b0;
    @(posedge clk); #1;
    chk("v_ack_drop", ack2, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [17:0] A_RD = 18'o001234;
  localparam logic [35:0] D_RD = 36'o123456701234;
  localparam logic [17:0] A_WR = 18'o000777;
  localparam logic [35:0] D_WR = 36'o777000123456;
  localparam logic [17:0] A_B  = 18'o070707;
  localparam logic [35:0] D_B  = 36'o012345670123;

  logic [15:0] wlanes [4];
  logic [17:0] pool [4];
  logic [17:0] ra, ma;
  logic [35:0] rdv, last_rd;
  int          lat, kind;
  bit          sw, so, cl, rdb, wrb, ub_seen;

  initial begin
    wlanes = '{16'o777, 16'o0, 16'o123, 16'o456};
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    rd2 = 1'b0; wr2 = 1'b0; a2 = '0; wd2 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    pl2_en = 1'b0; pl2_addr = '0; pl2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("rst_data_oe", sram_data_oe, 0);
    chk("rst_ack", mem_ack, 0);
    chk("rst_rdata", mem_read_data, 0);
    chk("rst_v_strobes", {ce2, oe2, we2, ub2, lb2}, 5'b11111);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed read: two clocks per beat, ack at edge 8
    preload(A_RD, D_RD);
    mem_read = 1'b1; mem_addr = A_RD;
    @(posedge clk);
    for (int e = 0; e < 8; e++) begin
      #1;
      chk("rd_addr", sram_addr, {A_RD, 2'(e / 2)});
      chk("rd_oe_n", oe_n, 0);
      chk("rd_ack_early", mem_ack, 0);
      @(posedge clk);
    end
    #1;
    chk("rd_ack_edge8", mem_ack, 1);
    chk("rd_data", mem_read_data, D_RD);
    mem_read = 1'b0;
    @(posedge clk); #1;
    chk("rd_ack_drop", mem_ack, 0);
    last_rd = D_RD;

    // directed write: WE_n low two clocks then one hold clock per beat
    mem_write = 1'b1; mem_addr = A_WR; mem_write_data = D_WR;
    @(posedge clk);
    for (int e = 0; e < 12; e++) begin
      #1;
      chk("wr_addr", sram_addr, {A_WR, 2'(e / 3)});
      chk("wr_we_n", we_n, (e % 3 == 2));
      chk("wr_data_oe", sram_data_oe, 1);
      chk("wr_ce_n", ce_n, 0);
      chk("wr_oe_n", oe_n, 1);
      chk("wr_dout", sram_data_out, wlanes[e / 3]);
      @(posedge clk);
    end
    #1;
    chk("wr_ack_edge12", mem_ack, 1);
    chk("wr_rdata_kept", mem_read_data, last_rd);
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("wr_ack_drop", mem_ack, 0);
    ref_mem[A_WR] = D_WR;

    run_txn(1'b1, 1'b0, A_WR, '0, 1'b0, 0, lat, sw, so, cl);
    chk("rb_lat", lat, 8);
    chk("rb_data", mem_read_data, D_WR);
    last_rd = D_WR;

    // handshake: held request, then a one-clock pulse
    run_txn(1'b1, 1'b0, A_RD, '0, 1'b0, 5, lat, sw, so, cl);
    chk("hold_lat", lat, 8);
    chk("hold_data", mem_read_data, D_RD);
    run_txn(1'b1, 1'b0, A_RD, '0, 1'b1, 0, lat, sw, so, cl);
    chk("pulse_lat", lat, 8);
    chk("pulse_data", mem_read_data, D_RD);

    // both requests: write wins
    run_txn(1'b1, 1'b1, A_B, D_B, 1'b0, 1, lat, sw, so, cl);
    chk("both_lat", lat, 12);
    chk("both_we", sw, 1);
    chk("both_oe", so, 0);
    chk("both_clash", cl, 0);
    ref_mem[A_B] = D_B;
    run_txn(1'b1, 1'b0, A_B, '0, 1'b0, 0, lat, sw, so, cl);
    chk("both_rb", mem_read_data, D_B);
    last_rd = D_B;

    // randomized traffic against the word-level reference
    for (int i = 0; i < 4; i++) begin
      pool[i] = {2'b10, 16'($urandom)};
      preload(pool[i], {4'($urandom), 32'($urandom)});
    end
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 2));
      ra   = pool[$urandom_range(0, 3)];
      rdv  = {4'($urandom), 32'($urandom)};
      rdb  = (kind != 1);
      wrb  = (kind != 0);
      run_txn(rdb, wrb, ra, rdv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), lat, sw, so, cl);
      if (wrb) begin
        ref_mem[ra] = rdv;
        chk("rnd_wr_lat", lat, 12);
        chk("rnd_wr_rdata_kept", mem_read_data, last_rd);
        chk("rnd_wr_we", sw, 1);
        chk("rnd_wr_oe", so, 0);
      end else begin
        chk("rnd_rd_lat", lat, 8);
        chk("rnd_rd_data", mem_read_data, ref_mem[ra]);
        chk("rnd_rd_we", sw, 0);
        last_rd = ref_mem[ra];
      end
      chk("rnd_clash", cl, 0);
    end

    // reset during write beat 2
    ma = 18'o040404;
    mem_write = 1'b1; mem_addr = ma; mem_write_data = {4'($urandom), 32'($urandom)};
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_beat2", sram_addr, {ma, 2'd2});
    reset = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("rstmid_data_oe", sram_data_oe, 0);
    chk("rstmid_ack", mem_ack, 0);
    chk("rstmid_rdata", mem_read_data, 0);
    reset = 1'b0;
    run_txn(1'b1, 1'b0, A_RD, '0, 1'b0, 0, lat, sw, so, cl);
    chk("rstmid_rd_lat", lat, 8);
    chk("rstmid_rd_data", mem_read_data, D_RD);

    // 32/8 variant
    preload2(8'h5A, 32'hDEADBEEF);
    run2(1'b1, 1'b0, 8'h5A, '0, lat, ub_seen);
    chk("v_rd_lat", lat, 4);
    chk("v_rd_ub", ub_seen, 0);
    chk("v_rd_data", rdata2, 32'hDEADBEEF);
    run2(1'b0, 1'b1, 8'h33, 32'h12345678, lat, ub_seen);
    chk("v_wr_lat", lat, 8);
    chk("v_wr_ub", ub_seen, 0);
    chk("v_wr_rdata_kept", rdata2, 32'hDEADBEEF);
    run2(1'b1, 1'b0, 8'h33, '0, lat, ub_seen);
    chk("v_rb_data", rdata2, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
